mio_arbiter: RTL

Two-master memory/IO bus arbiter that shares the single CPU-side memory/MIO port (address, write data, write strobe, `MIO_ready` handshake, read data) between an instruction-fetch requester (port 0) and a data load/store or DMA requester (port 1). It grants one requester at a time with round-robin fairness. It latches and holds the request onto the memory side until `MIO_ready`, and returns read data with a one-cycle acknowledge. A wait-state timeout prevents the bus from hanging on an unresponsive device. It sits between the processor/peripheral masters and the memory-IO interface.

---
 rtl/mio_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mio_arbiter.sv
// Two-master round-robin arbiter sharing one memory/IO port between instruction
// fetch (port 0) and load/store/DMA (port 1), with a wait-state timeout.
module mio_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          MIO_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic w_any;
    logic w_win1;
    logic w_access;
    logic w_resp;

    // On a tie the port that did not win last time gets the bus.
    assign w_any    = req0 | req1;
    assign w_win1   = req1 & (~req0 | ~r_last);
    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win1;
                        r_last  <= w_win1;
                        r_cnt   <= '0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A ready arriving on the last allowed cycle still counts as success.
                    if (MIO_ready) begin
                        r_rdata <= r_we ? '0 : mem_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_MAX) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request payload is captured only at the arbitration edge; outputs are gated by state.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any) begin
            r_we    <= w_win1 ? we1    : we0;
            r_addr  <= w_win1 ? addr1  : addr0;
            r_wdata <= w_win1 ? wdata1 : wdata0;
        end
    end

    assign mem_req   = w_access;
    assign mem_w     = w_access & r_we;
    assign mem_addr  = w_access ? r_addr  : '0;
    assign mem_wdata = w_access ? r_wdata : '0;

    assign gnt0  = (w_access | w_resp) & ~r_owner;
    assign gnt1  = (w_access | w_resp) &  r_owner;
    assign ack0  = w_resp & ~r_owner;
    assign ack1  = w_resp &  r_owner;
    assign rdata = r_rdata;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule
